// File: rtl/alu_issue_ctrl_if.sv
// Issue-stage bus for alu_issue_ctrl.
// It groups the request handshake, the ALU-facing operand and opcode lines, and the
// result/status outputs.
//   master : the requester and the ALU (drives the request fields and alu_out)
//   slave  : alu_issue_ctrl (drives in_ready, the ALU operands/opcode and the result)
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  shamt;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [2:0]  ALUOp;
  logic [31:0] alu_out;
  logic        out_valid;
  logic [31:0] out_data;
  logic        illegal;
  logic        busy;

  modport master (
    output in_valid, funct, rs_data, rt_data, shamt, alu_out,
    input  in_ready, dataA, dataB, ALUOp, out_valid, out_data, illegal, busy
  );

  modport slave (
    input  in_valid, funct, rs_data, rt_data, shamt, alu_out,
    output in_ready, dataA, dataB, ALUOp, out_valid, out_data, illegal, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue and sequencing stage in front of the TotalALU datapath.
// It accepts an R-type funct and its operands on a valid/ready handshake, then registers
// the operands and the ALUOp. For simple ops it waits SIMPLE_LAT cycles and captures alu_out.
// For MULTU it holds the multiplier for MULT_CYCLES cycles, adds one HiLo capture cycle, and
// reports 0. An illegal funct is reported without touching the ALU lines.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - alu_issue_ctrl_if.slave (handshake, ALU operands/opcode, result, status)
module alu_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned SIMPLE_LAT  = 1
) (
  input logic             clk,
  input logic             reset,
  alu_issue_ctrl_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(MULT_CYCLES + 1);
  localparam logic [CntW-1:0] MulLast  = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] ExecLast = CntW'(SIMPLE_LAT - 1);

  localparam logic [2:0] OpAdd   = 3'b010;
  localparam logic [2:0] OpSll   = 3'b011;
  localparam logic [2:0] OpMultu = 3'b100;

  typedef enum logic [2:0] {StIdle, StExec, StMul, StHilo, StDone} state_e;

  state_e          r_state,    w_state_nxt;
  logic [CntW-1:0] r_cnt,      w_cnt_nxt;
  logic [31:0]     r_data_a,   w_data_a_nxt;
  logic [31:0]     r_data_b,   w_data_b_nxt;
  logic [2:0]      r_alu_op,   w_alu_op_nxt;
  logic [31:0]     r_out_data, w_out_data_nxt;
  logic            r_illegal,  w_illegal_nxt;

  logic       w_legal;
  logic [2:0] w_dec_op;

  // funct decode
  always_comb begin
    w_legal  = 1'b1;
    w_dec_op = OpAdd;
    case (bus.funct)
      6'b100100: w_dec_op = 3'b000;
      6'b100101: w_dec_op = 3'b001;
      6'b100000: w_dec_op = 3'b010;
      6'b000000: w_dec_op = 3'b011;
      6'b011001: w_dec_op = 3'b100;
      6'b010000: w_dec_op = 3'b101;
      6'b100010: w_dec_op = 3'b110;
      6'b010010: w_dec_op = 3'b111;
      default:   w_legal  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_alu_op   <= OpAdd;
      r_out_data <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data_a   <= w_data_a_nxt;
      r_data_b   <= w_data_b_nxt;
      r_alu_op   <= w_alu_op_nxt;
      r_out_data <= w_out_data_nxt;
      r_illegal  <= w_illegal_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_data_a_nxt   = r_data_a;
    w_data_b_nxt   = r_data_b;
    w_alu_op_nxt   = r_alu_op;
    w_out_data_nxt = r_out_data;
    w_illegal_nxt  = r_illegal;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          if (!w_legal) begin
            // Leave operands and ALUOp alone so the ALU never sees the bad request.
            w_state_nxt    = StDone;
            w_illegal_nxt  = 1'b1;
            w_out_data_nxt = '0;
          end else begin
            w_alu_op_nxt = w_dec_op;
            w_cnt_nxt    = '0;
            if (w_dec_op == OpSll) begin
              w_data_a_nxt = bus.rt_data;
              w_data_b_nxt = {27'b0, bus.shamt};
            end else begin
              w_data_a_nxt = bus.rs_data;
              w_data_b_nxt = bus.rt_data;
            end
            w_state_nxt = (w_dec_op == OpMultu) ? StMul : StExec;
          end
        end
      end
      StExec: begin
        if (r_cnt == ExecLast) begin
          w_out_data_nxt = bus.alu_out;
          w_state_nxt    = StDone;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      StMul: begin
        if (r_cnt == MulLast) begin
          w_state_nxt = StHilo;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      StHilo: begin
        // HiLo captures this cycle. Drop back to ADD so the multiplier does not restart.
        w_out_data_nxt = '0;
        w_alu_op_nxt   = OpAdd;
        w_state_nxt    = StDone;
      end
      StDone: begin
        w_illegal_nxt = 1'b0;
        w_state_nxt   = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.busy      = (r_state != StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.out_data  = r_out_data;
  assign bus.illegal   = r_illegal;
  assign bus.dataA     = r_data_a;
  assign bus.dataB     = r_data_b;
  assign bus.ALUOp     = r_alu_op;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl.
// A small ALU stand-in sits on the bus: it computes a combinational result and holds a
// HiLo pair that loads while ALUOp is MULTU.
module tb_alu_issue_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(
    .MULT_CYCLES (32),
    .SIMPLE_LAT  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in
  logic [31:0] hi, lo;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (bus.ALUOp == 3'b100) begin
      {hi, lo} <= {32'b0, bus.dataA} * {32'b0, bus.dataB};
    end
  end

  always_comb begin
    bus.alu_out = '0;
    case (bus.ALUOp)
      3'b000:  bus.alu_out = bus.dataA & bus.dataB;
      3'b001:  bus.alu_out = bus.dataA | bus.dataB;
      3'b010:  bus.alu_out = bus.dataA + bus.dataB;
      3'b011:  bus.alu_out = bus.dataA << bus.dataB[4:0];
      3'b101:  bus.alu_out = hi;
      3'b110:  bus.alu_out = bus.dataA - bus.dataB;
      3'b111:  bus.alu_out = lo;
      default: bus.alu_out = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Present a request and hold it through the accept edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    bus.funct    = f;
    bus.rs_data  = a;
    bus.rt_data  = b;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
    check("issue_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid with a cycle bound, then check latency, result and pulse width.
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_data,
                           input logic exp_ill);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, bus.out_data, exp_data);
    check({tag, "_illegal"}, 32'(bus.illegal), 32'(exp_ill));
    tick();
    check({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ill_clr"}, 32'(bus.illegal), 32'd0);
  endtask

  initial begin
    int mul_cnt;
    int guard;
    logic rdy_seen;
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.funct    = '0;
    bus.rs_data  = '0;
    bus.rt_data  = '0;
    bus.shamt    = '0;
    repeat (2) tick();

    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_dataA", bus.dataA, 32'd0);
    check("rst_dataB", bus.dataB, 32'd0);
    check("rst_aluop", 32'(bus.ALUOp), 32'd2);
    reset = 1'b1;
    tick();

    // ADD 5+7, step by step
    issue(6'b100000, 32'd5, 32'd7, 5'd0);
    check("add_aluop", 32'(bus.ALUOp), 32'd2);
    check("add_busy", 32'(bus.busy), 32'd1);
    check("add_not_ready", 32'(bus.in_ready), 32'd0);
    check("add_no_valid_yet", 32'(bus.out_valid), 32'd0);
    wait_done("add", 1, 32'd12, 1'b0);
    check("add_idle_ready", 32'(bus.in_ready), 32'd1);

    // MFHI before any MULTU gives the HiLo reset value
    issue(6'b010000, 32'd0, 32'd0, 5'd0);
    wait_done("mfhi0", 1, 32'd0, 1'b0);

    issue(6'b100010, 32'h0000F0F0, 32'h00000FF0, 5'd0);
    check("sub_aluop", 32'(bus.ALUOp), 32'd6);
    wait_done("sub", 1, 32'h0000E100, 1'b0);
    issue(6'b100100, 32'h0000F0F0, 32'h00000FF0, 5'd0);
    wait_done("and", 1, 32'h000000F0, 1'b0);
    issue(6'b100101, 32'h0000F0F0, 32'h00000FF0, 5'd0);
    check("or_aluop", 32'(bus.ALUOp), 32'd1);
    wait_done("or", 1, 32'h0000FFF0, 1'b0);

    // Illegal funct: ALUOp keeps OR, result pulse right after accept
    issue(6'b101010, 32'h12345678, 32'h9ABCDEF0, 5'd3);
    check("ill_aluop_kept", 32'(bus.ALUOp), 32'd1);
    check("ill_dataA_kept", bus.dataA, 32'h0000F0F0);
    check("ill_valid", 32'(bus.out_valid), 32'd1);
    wait_done("ill", 0, 32'd0, 1'b1);

    // SLL with a second request (AND) held valid while busy
    issue(6'b000000, 32'hDEADBEEF, 32'd1, 5'd31);
    bus.funct    = 6'b100100;
    bus.rs_data  = 32'h0000FF00;
    bus.rt_data  = 32'h00000FF0;
    bus.in_valid = 1'b1;
    check("sll_dataA", bus.dataA, 32'd1);
    check("sll_dataB", bus.dataB, 32'd31);
    check("sll_aluop", 32'(bus.ALUOp), 32'd3);
    check("held_not_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("sll_valid", 32'(bus.out_valid), 32'd1);
    check("sll_data", bus.out_data, 32'h80000000);
    check("sll_dataA_stable", bus.dataA, 32'd1);
    tick();
    check("held_ready_again", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("held_accepted", 32'(bus.busy), 32'd1);
    check("held_aluop", 32'(bus.ALUOp), 32'd0);
    wait_done("held_and", 1, 32'h00000F00, 1'b0);

    // MULTU 0xFFFFFFFF * 2
    issue(6'b011001, 32'hFFFFFFFF, 32'd2, 5'd0);
    mul_cnt  = 0;
    guard    = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && guard < 200) begin
      if (bus.ALUOp == 3'b100) mul_cnt++;
      if (bus.in_ready) rdy_seen = 1'b1;
      tick();
      guard++;
    end
    check("mul_aluop_cycles", 32'(mul_cnt), 32'd33);
    check("mul_ready_low", 32'(rdy_seen), 32'd0);
    check("mul_lat", 32'(guard), 32'd33);
    check("mul_data", bus.out_data, 32'd0);
    check("mul_aluop_released", 32'(bus.ALUOp), 32'd2);
    tick();
    check("mul_pulse", 32'(bus.out_valid), 32'd0);
    issue(6'b010000, 32'd0, 32'd0, 5'd0);
    check("mfhi_aluop", 32'(bus.ALUOp), 32'd5);
    wait_done("mfhi", 1, 32'd1, 1'b0);
    issue(6'b010010, 32'd0, 32'd0, 5'd0);
    wait_done("mflo", 1, 32'hFFFFFFFE, 1'b0);

    // Reset at MUL cycle 10
    issue(6'b011001, 32'd3, 32'd4, 5'd0);
    repeat (10) tick();
    check("mid_mul_aluop", 32'(bus.ALUOp), 32'd4);
    reset = 1'b0;
    #1;
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_aluop", 32'(bus.ALUOp), 32'd2);
    check("mrst_dataA", bus.dataA, 32'd0);
    check("mrst_dataB", bus.dataB, 32'd0);
    check("mrst_out_data", bus.out_data, 32'd0);
    tick();
    check("mrst_hold_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    issue(6'b100000, 32'd1, 32'd1, 5'd0);
    wait_done("add_after_rst", 1, 32'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
